// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle 6502-subset sequencer driving a req/ack memory port.
// Holds A, X, Y, P and PC; fetches, decodes and executes one instruction at a time.
module mc_control_unit #(
   parameter logic [15:0] RESET_PC = 16'h1000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   output logic             mem_req,
   output logic             mem_we,
   output logic [15:0]      mem_addr,
   output logic [7:0]       mem_wdata,
   input  logic [7:0]       mem_rdata,
   input  logic             mem_ack,
   output logic [7:0]       a_out,
   output logic [7:0]       x_out,
   output logic [7:0]       y_out,
   output logic [7:0]       p_out,
   output logic [15:0]      pc_out,
   output logic             halted,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH, S_OPER, S_READ, S_EXEC, S_WRITE, S_HALT
   } state_e;

   typedef enum logic [2:0] {
      M_IMP, M_IMM, M_ZP, M_ABS, M_ABSX, M_REL
   } mode_e;

   typedef enum logic [4:0] {
      OP_ILL, OP_LDA, OP_LDX, OP_LDY, OP_STA, OP_ADC, OP_SBC, OP_AND,
      OP_ORA, OP_EOR, OP_INX, OP_INY, OP_DEX, OP_DEY, OP_CLC, OP_SEC,
      OP_JMP, OP_BEQ, OP_BNE, OP_NOP
   } op_e;

   typedef struct packed {
      op_e   op;
      mode_e mode;
   } dec_t;

   function automatic dec_t decode(input logic [7:0] opc);
      dec_t d;
      d.op   = OP_ILL;
      d.mode = M_IMP;
      case (opc)
         8'hA9: begin d.op = OP_LDA; d.mode = M_IMM;  end
         8'hA5: begin d.op = OP_LDA; d.mode = M_ZP;   end
         8'hAD: begin d.op = OP_LDA; d.mode = M_ABS;  end
         8'hBD: begin d.op = OP_LDA; d.mode = M_ABSX; end
         8'hA2: begin d.op = OP_LDX; d.mode = M_IMM;  end
         8'hA0: begin d.op = OP_LDY; d.mode = M_IMM;  end
         8'h85: begin d.op = OP_STA; d.mode = M_ZP;   end
         8'h8D: begin d.op = OP_STA; d.mode = M_ABS;  end
         8'h9D: begin d.op = OP_STA; d.mode = M_ABSX; end
         8'h69: begin d.op = OP_ADC; d.mode = M_IMM;  end
         8'h65: begin d.op = OP_ADC; d.mode = M_ZP;   end
         8'h6D: begin d.op = OP_ADC; d.mode = M_ABS;  end
         8'hE9: begin d.op = OP_SBC; d.mode = M_IMM;  end
         8'h29: begin d.op = OP_AND; d.mode = M_IMM;  end
         8'h09: begin d.op = OP_ORA; d.mode = M_IMM;  end
         8'h49: begin d.op = OP_EOR; d.mode = M_IMM;  end
         8'hE8: d.op = OP_INX;
         8'hC8: d.op = OP_INY;
         8'hCA: d.op = OP_DEX;
         8'h88: d.op = OP_DEY;
         8'h18: d.op = OP_CLC;
         8'h38: d.op = OP_SEC;
         8'h4C: begin d.op = OP_JMP; d.mode = M_ABS;  end
         8'hF0: begin d.op = OP_BEQ; d.mode = M_REL;  end
         8'hD0: begin d.op = OP_BNE; d.mode = M_REL;  end
         8'hEA: d.op = OP_NOP;
         default: d.op = OP_ILL;
      endcase
      return d;
   endfunction

   function automatic logic [1:0] instr_size(input mode_e m);
      logic [1:0] s;
      case (m)
         M_IMP:                s = 2'd1;
         M_IMM, M_ZP, M_REL:   s = 2'd2;
         default:              s = 2'd3;
      endcase
      return s;
   endfunction

   state_e           state_q, state_d;
   logic [15:0]      pc_q, pc_d;
   logic [7:0]       a_q, a_d, x_q, x_d, y_q, y_d, p_q, p_d;
   logic [7:0]       ir_q, ir_d, lo_q, lo_d, hi_q, hi_d, m_q, m_d;
   logic             opidx_q, opidx_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   dec_t        dec_f, dec_r;
   logic [1:0]  size_r;
   logic [15:0] ea, pc_seq, br_tgt;
   logic [7:0]  opnd;
   logic        reads_mem;

   assign dec_f     = decode(mem_rdata);
   assign dec_r     = decode(ir_q);
   assign size_r    = instr_size(dec_r.mode);
   assign pc_seq    = pc_q + {14'd0, size_r};
   assign br_tgt    = pc_q + 16'd2 + {{8{lo_q[7]}}, lo_q};
   assign opnd      = (dec_r.mode == M_IMM) ? lo_q : m_q;
   assign reads_mem = ((dec_r.mode == M_ZP) || (dec_r.mode == M_ABS) || (dec_r.mode == M_ABSX))
                      && (dec_r.op != OP_STA) && (dec_r.op != OP_JMP);

   // Effective address for data reads and stores (abs,X wraps at 16 bits).
   always_comb begin
      case (dec_r.mode)
         M_ZP:    ea = {8'h00, lo_q};
         M_ABSX:  ea = {hi_q, lo_q} + {8'h00, x_q};
         default: ea = {hi_q, lo_q};
      endcase
   end

   logic [7:0]  ex_a, ex_x, ex_y, ex_p, addend, nz_val;
   logic [15:0] ex_pc;
   logic [8:0]  sum;
   logic        set_nz;

   // Execute datapath: architectural results of the decoded instruction.
   always_comb begin
      ex_a   = a_q;
      ex_x   = x_q;
      ex_y   = y_q;
      ex_p   = p_q;
      ex_pc  = pc_seq;
      nz_val = 8'h00;
      set_nz = 1'b0;
      addend = (dec_r.op == OP_SBC) ? ~opnd : opnd;
      sum    = {1'b0, a_q} + {1'b0, addend} + {8'd0, p_q[0]};
      case (dec_r.op)
         OP_LDA: begin ex_a = opnd; nz_val = opnd; set_nz = 1'b1; end
         OP_LDX: begin ex_x = opnd; nz_val = opnd; set_nz = 1'b1; end
         OP_LDY: begin ex_y = opnd; nz_val = opnd; set_nz = 1'b1; end
         OP_ADC, OP_SBC: begin
            ex_a    = sum[7:0];
            nz_val  = sum[7:0];
            set_nz  = 1'b1;
            ex_p[0] = sum[8];
            ex_p[6] = (a_q[7] ^ sum[7]) & (addend[7] ^ sum[7]);
         end
         OP_AND: begin ex_a = a_q & opnd; nz_val = a_q & opnd; set_nz = 1'b1; end
         OP_ORA: begin ex_a = a_q | opnd; nz_val = a_q | opnd; set_nz = 1'b1; end
         OP_EOR: begin ex_a = a_q ^ opnd; nz_val = a_q ^ opnd; set_nz = 1'b1; end
         OP_INX: begin ex_x = x_q + 8'd1; nz_val = x_q + 8'd1; set_nz = 1'b1; end
         OP_INY: begin ex_y = y_q + 8'd1; nz_val = y_q + 8'd1; set_nz = 1'b1; end
         OP_DEX: begin ex_x = x_q - 8'd1; nz_val = x_q - 8'd1; set_nz = 1'b1; end
         OP_DEY: begin ex_y = y_q - 8'd1; nz_val = y_q - 8'd1; set_nz = 1'b1; end
         OP_CLC: ex_p[0] = 1'b0;
         OP_SEC: ex_p[0] = 1'b1;
         OP_JMP: ex_pc = {hi_q, lo_q};
         OP_BEQ: if (p_q[1])  ex_pc = br_tgt;
         OP_BNE: if (!p_q[1]) ex_pc = br_tgt;
         default: ;
      endcase
      if (set_nz) begin
         ex_p[1] = (nz_val == 8'h00);
         ex_p[7] = nz_val[7];
      end
   end

   // Sequencer: next state, memory request and register updates.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      a_d       = a_q;
      x_d       = x_q;
      y_d       = y_q;
      p_d       = p_q;
      ir_d      = ir_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      m_d       = m_q;
      opidx_d   = opidx_q;
      pend_d    = 1'b0;
      instret_d = instret_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc_q;
      mem_wdata = a_q;
      case (state_q)
         S_FETCH: begin
            // Once a fetch is issued it is held until ack, even if run drops.
            mem_req  = run | pend_q;
            mem_addr = pc_q;
            if (mem_req && mem_ack) begin
               ir_d    = mem_rdata;
               opidx_d = 1'b0;
               if (dec_f.op == OP_ILL)       state_d = S_HALT;
               else if (dec_f.mode == M_IMP) state_d = S_EXEC;
               else                          state_d = S_OPER;
            end else begin
               pend_d = mem_req;
            end
         end
         S_OPER: begin
            mem_req  = 1'b1;
            mem_addr = pc_q + (opidx_q ? 16'd2 : 16'd1);
            if (mem_ack) begin
               if (!opidx_q) lo_d = mem_rdata;
               else          hi_d = mem_rdata;
               if (opidx_q || (size_r == 2'd2)) begin
                  if (reads_mem)                state_d = S_READ;
                  else if (dec_r.op == OP_STA)  state_d = S_WRITE;
                  else                          state_d = S_EXEC;
               end else begin
                  opidx_d = 1'b1;
               end
            end
         end
         S_READ: begin
            mem_req  = 1'b1;
            mem_addr = ea;
            if (mem_ack) begin
               m_d     = mem_rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            a_d       = ex_a;
            x_d       = ex_x;
            y_d       = ex_y;
            p_d       = ex_p;
            pc_d      = ex_pc;
            instret_d = instret_q + CNT_W'(1);
            state_d   = S_FETCH;
         end
         S_WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ea;
            mem_wdata = a_q;
            if (mem_ack) begin
               pc_d      = pc_seq;
               instret_d = instret_q + CNT_W'(1);
               state_d   = S_FETCH;
            end
         end
         S_HALT: ;
         default: state_d = S_FETCH;
      endcase
      if (reset) mem_req = 1'b0;
   end

   // State and architectural registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         a_q       <= '0;
         x_q       <= '0;
         y_q       <= '0;
         p_q       <= '0;
         ir_q      <= '0;
         lo_q      <= '0;
         hi_q      <= '0;
         m_q       <= '0;
         opidx_q   <= 1'b0;
         pend_q    <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         a_q       <= a_d;
         x_q       <= x_d;
         y_q       <= y_d;
         p_q       <= p_d;
         ir_q      <= ir_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         m_q       <= m_d;
         opidx_q   <= opidx_d;
         pend_q    <= pend_d;
         instret_q <= instret_d;
      end
   end

   assign a_out   = a_q;
   assign x_out   = x_q;
   assign y_out   = y_q;
   assign p_out   = p_q;
   assign pc_out  = pc_q;
   assign halted  = (state_q == S_HALT);
   assign instret = instret_q;

endmodule
